dmux1t8_32: RTL

Registered 1-to-8 demultiplexer for 32-bit words with valid/ready handshaking. It is the distribution counterpart of the 8:1 32-bit selector. One upstream producer pushes a word plus a 3-bit destination select; the block holds the word in a single-entry buffer and presents it to exactly one of eight downstream consumers until that consumer accepts it. It sits between the datapath/bus side and up to eight peripheral or display sinks.

---
 rtl/dmux_pkg.sv | 26 ++
 rtl/dmux1t8_32_dec3t8.sv | 29 ++
 rtl/dmux1t8_32.sv | 115 +++++++++++
 3 files changed

// File: rtl/dmux_pkg.sv
// -----------------------------------------------------------------------------
// dmux_pkg
// Shared definitions for the dmux1t8_32 registered 1-to-8 demultiplexer.
//   NCH      : number of downstream channels (8)
//   SEL_W    : width of a channel select (3)
//   dmux_state_e : single-entry buffer state {EMPTY, FULL}
//   onehot() : SEL_W-bit index to NCH-bit one-hot vector
// -----------------------------------------------------------------------------
package dmux_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } dmux_state_e;

    function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NCH-1:0] vec;
        vec = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage : dmux_pkg

// File: rtl/dmux1t8_32_dec3t8.sv
// -----------------------------------------------------------------------------
// dec3t8
// Combinational 3-to-8 one-hot decoder with enable. Produces the per-channel
// valid vector of the demultiplexer from the stored select, gated by the
// buffer-full condition so that an empty buffer never flags any channel.
// Ports:
//   sel_i  [2:0]  channel index
//   en_i          enable (buffer full)
//   dec_o  [7:0]  one-hot output, all zero when en_i is low
// -----------------------------------------------------------------------------
module dec3t8
    import dmux_pkg::*;
(
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [NCH-1:0]   dec_o
);

    logic [NCH-1:0] hot;

    assign hot = onehot(sel_i);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_gate
            assign dec_o[gi] = hot[gi] & en_i;
        end
    endgenerate

endmodule : dec3t8

// File: rtl/dmux1t8_32.sv
// -----------------------------------------------------------------------------
// dmux1t8_32
// Registered 1-to-8 demultiplexer for DW-bit words with valid/ready
// handshaking. A single-entry buffer holds one word and presents it to the
// addressed consumer until that consumer accepts it. A drain and a new accept
// may happen on the same edge, giving one word per cycle of throughput.
//
// Build option:
//   DMUX_ROUND_ROBIN_EN  when defined, in_sel is ignored and an internal
//                        pointer (rr_ptr) cycles the destination 0..7 on
//                        every accepted word.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_data    [DW-1:0]  word to distribute
//   in_sel     [2:0]     destination channel, sampled with in_data
//   in_valid             upstream offers a word
//   in_ready             block accepts this cycle (combinational from out_ready)
//   out_data   [DW-1:0]  held word, shared by all channels
//   out_valid  [7:0]     one-hot pending-word flag per channel
//   out_ready  [7:0]     per-channel consumer ready
// -----------------------------------------------------------------------------
module dmux1t8_32
    import dmux_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    out_data,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready
);

    dmux_state_e      state_q, state_d;
    logic [DW-1:0]    data_q,  data_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic [SEL_W-1:0] dest;
    logic             full;
    logic             drain;
    logic             accept;

    assign full   = (state_q == FULL);
    // Only the addressed consumer's ready matters; the rest are ignored.
    assign drain  = full && out_ready[sel_q];
    // Ready also while draining so a new word can replace the old one in the
    // same edge.
    assign in_ready = !full || drain;
    assign accept   = in_valid && in_ready;

`ifdef DMUX_ROUND_ROBIN_EN
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             unused_in_sel;

    assign unused_in_sel = ^in_sel;
    assign dest          = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = rr_ptr_q + SEL_W'(1); // wraps 7 -> 0 naturally
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign dest = in_sel;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (accept) begin
            state_d = FULL;
            data_d  = in_data;
            sel_d   = dest;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    // data_q keeps its value after a drain; consumers qualify with out_valid.
    assign out_data = data_q;

    dec3t8 u_dec (
        .sel_i (sel_q),
        .en_i  (full),
        .dec_o (out_valid)
    );

endmodule : dmux1t8_32
